// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: spawns moles on five holes from an LFSR,
// times them out on a prescaled tick, and scores hits and misses.
module mole_scheduler #(
  parameter int unsigned TICK_DIV   = 5000000,
  parameter int unsigned MOLE_LIFE  = 10,
  parameter int unsigned SPAWN_GAP  = 5,
  parameter int unsigned MAX_ACTIVE = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] hit,
  output logic [4:0] moles,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [4:0] escape_mask,
  output logic [2:0] active_count,
  output logic       busy
);
  localparam int unsigned NH = 5;
  localparam int unsigned PW = 28;
  localparam int unsigned CW = 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [CW-1:0]         gap_q, gap_d, gap_dec;
  logic [NH-1:0][CW-1:0] life_q, life_d;
  logic [NH-1:0]         moles_q, moles_d, escape_q, escape_d;
  logic                  hit_pulse_q, hit_pulse_d, miss_pulse_q, miss_pulse_d;
  logic                  busy_q, busy_d;
  logic [2:0]            hit_prev_q, hit_prev_d, hit_idx;
  logic [2:0]            spawn_base, spawn_idx;
  logic [3:0]            probe;
  logic [7:0]            lfsr_q, lfsr_d;
  logic                  tick, hit_eval, spawn_found;

  // Occupancy is taken from the registered moles, so holes freed this cycle stay blocked.
  always_comb begin
    active_count = '0;
    for (int i = 0; i < NH; i++) active_count = active_count + 3'(moles_q[i]);
  end

  always_comb begin
    spawn_base  = (lfsr_q[2:0] >= 3'd5) ? lfsr_q[2:0] - 3'd5 : lfsr_q[2:0];
    spawn_found = 1'b0;
    spawn_idx   = '0;
    probe       = '0;
    for (int k = 0; k < NH; k++) begin
      probe = 4'(spawn_base) + 4'(k);
      if (probe >= 4'd5) probe = probe - 4'd5;
      if (!spawn_found && !moles_q[probe[2:0]]) begin
        spawn_found = 1'b1;
        spawn_idx   = probe[2:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    gap_d        = gap_q;
    life_d       = life_q;
    moles_d      = moles_q;
    escape_d     = '0;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    hit_prev_d   = hit;
    lfsr_d       = lfsr_q;
    tick         = (presc_q == '0);
    gap_dec      = (gap_q != '0) ? gap_q - CW'(1) : '0;
    hit_eval     = (hit != hit_prev_q) && (hit != 3'd0) && (hit <= 3'd5);
    hit_idx      = hit - 3'd1;

    if (state_q == RUN) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          presc_d = PW'(TICK_DIV - 1);
          gap_d   = CW'(1);
          life_d  = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          presc_d = '0;
          gap_d   = '0;
          life_d  = '0;
          moles_d = '0;
        end else begin
          presc_d = tick ? PW'(TICK_DIV - 1) : presc_q - PW'(1);
          if (tick) begin
            for (int i = 0; i < NH; i++) begin
              if (moles_q[i]) begin
                if (life_q[i] == CW'(1)) begin
                  moles_d[i]  = 1'b0;
                  life_d[i]   = '0;
                  escape_d[i] = 1'b1;
                end else begin
                  life_d[i] = life_q[i] - CW'(1);
                end
              end
            end
            gap_d = gap_dec;
            // A full board leaves gap at zero so the spawn retries on the next tick.
            if (gap_dec == '0 && active_count < 3'(MAX_ACTIVE) && spawn_found) begin
              moles_d[spawn_idx] = 1'b1;
              life_d[spawn_idx]  = CW'(MOLE_LIFE);
              gap_d              = CW'(SPAWN_GAP);
            end
          end
          // Hit overrides an expiry landing on the same hole.
          if (hit_eval) begin
            if (moles_q[hit_idx]) begin
              moles_d[hit_idx]  = 1'b0;
              life_d[hit_idx]   = '0;
              escape_d[hit_idx] = 1'b0;
              hit_pulse_d       = 1'b1;
            end else begin
              miss_pulse_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      gap_q        <= '0;
      life_q       <= '0;
      moles_q      <= '0;
      escape_q     <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      hit_prev_q   <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      gap_q        <= gap_d;
      life_q       <= life_d;
      moles_q      <= moles_d;
      escape_q     <= escape_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      busy_q       <= busy_d;
      hit_prev_q   <= hit_prev_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign moles       = moles_q;
  assign hit_pulse   = hit_pulse_q;
  assign miss_pulse  = miss_pulse_q;
  assign escape_mask = escape_q;
  assign busy        = busy_q;

endmodule
